// File: rtl/dcache_direct.sv
// rtl/dcache_direct.sv - direct-mapped write-through no-write-allocate data cache
//
// Holds one 32-bit big-endian word per set. Read hits are served
// combinationally; read misses stall two cycles while the line is refilled.
// Stores always pass straight through to memory, and update the cached copy
// only on a hit. A level flush request invalidates every line, one per cycle.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   cpu_re / cpu_we       read / write request (write wins when both are set)
//   cpu_byteop            1 = byte access, 0 = word access
//   cpu_addr, cpu_wdata   byte address and store data (byte stores use [7:0])
//   cpu_rdata, cpu_stall  load data and stall (CPU holds its request while high)
//   flush, flush_busy     invalidate-all request and in-progress indication
//   mem_*                 data memory port (mem_rdata is combinational on mem_addr)
//   hit_count, miss_count saturating read hit / miss statistics
module dcache_direct #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int BYTE_WIDTH    = 8,
  parameter int SETS          = 8,
  parameter int CNT_WIDTH     = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cpu_re,
  input  logic                     cpu_we,
  input  logic                     cpu_byteop,
  input  logic [ADDRESS_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0]    cpu_wdata,
  output logic [DATA_WIDTH-1:0]    cpu_rdata,
  output logic                     cpu_stall,
  input  logic                     flush,
  output logic                     flush_busy,
  output logic                     mem_we,
  output logic                     mem_byteop,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]    mem_wdata,
  input  logic [DATA_WIDTH-1:0]    mem_rdata,
  output logic [CNT_WIDTH-1:0]     hit_count,
  output logic [CNT_WIDTH-1:0]     miss_count
);

  localparam int IDX   = $clog2(SETS);
  localparam int TAG_W = ADDRESS_WIDTH - IDX - 2;

  typedef enum logic [1:0] {IDLE, FILL, FLUSH} state_t;

  state_t                state;
  logic [SETS-1:0]       valid;
  logic [TAG_W-1:0]      tag_array  [SETS];
  logic [DATA_WIDTH-1:0] data_array [SETS];
  logic [IDX-1:0]        flush_idx;
  logic                  just_filled;

  logic [IDX-1:0]        index;
  logic [TAG_W-1:0]      tag;
  logic [1:0]            offset;
  logic [4:0]            lane_lsb;
  logic [DATA_WIDTH-1:0] line;
  logic                  hit;
  logic                  do_write;
  logic                  do_read;

  assign index  = cpu_addr[IDX+1:2];
  assign tag    = cpu_addr[ADDRESS_WIDTH-1:IDX+2];
  assign offset = cpu_addr[1:0];
  // Big-endian lanes: offset 0 is bits [31:24], offset 3 is bits [7:0].
  assign lane_lsb = {~offset, 3'b000};
  assign line     = data_array[index];
  assign hit      = valid[index] && (tag_array[index] == tag);

  // A pending flush blocks any request in the same cycle.
  assign do_write = (state == IDLE) && !flush && cpu_we;
  assign do_read  = (state == IDLE) && !flush && !cpu_we && cpu_re;

  assign cpu_rdata  = cpu_byteop ? {{(DATA_WIDTH-BYTE_WIDTH){1'b0}}, line[lane_lsb +: BYTE_WIDTH]}
                                 : line;
  assign cpu_stall  = (state != IDLE) || flush || (do_read && !hit);
  assign flush_busy = (state == FLUSH);

  assign mem_we     = do_write;
  assign mem_byteop = (state == FILL) ? 1'b0 : cpu_byteop;
  assign mem_addr   = (state == FILL) ? {cpu_addr[ADDRESS_WIDTH-1:2], 2'b00} : cpu_addr;
  assign mem_wdata  = cpu_wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      valid       <= '0;
      flush_idx   <= '0;
      just_filled <= 1'b0;
      hit_count   <= '0;
      miss_count  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (flush) begin
            state <= FLUSH;
          end else if (do_read) begin
            if (hit) begin
              // The first hit after a refill is the missed load completing,
              // so it is not counted as a hit.
              if (!just_filled && (hit_count != '1))
                hit_count <= hit_count + CNT_WIDTH'(1);
              just_filled <= 1'b0;
            end else begin
              state <= FILL;
              if (miss_count != '1)
                miss_count <= miss_count + CNT_WIDTH'(1);
            end
          end
        end
        FILL: begin
          valid[index] <= 1'b1;
          just_filled  <= 1'b1;
          state        <= IDLE;
        end
        FLUSH: begin
          valid[flush_idx] <= 1'b0;
          if (flush_idx == IDX'(SETS - 1)) begin
            flush_idx <= '0;
            state     <= IDLE;
          end else begin
            flush_idx <= flush_idx + IDX'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Tag and data storage need no reset: valid bits alone qualify them.
  always_ff @(posedge clk) begin
    if (state == FILL) begin
      data_array[index] <= mem_rdata;
      tag_array[index]  <= tag;
    end else if (do_write && hit) begin
      if (cpu_byteop)
        data_array[index][lane_lsb +: BYTE_WIDTH] <= cpu_wdata[BYTE_WIDTH-1:0];
      else
        data_array[index] <= cpu_wdata;
    end
  end

endmodule

// File: tb/tb_dcache_direct.sv
// tb/tb_dcache_direct.sv - scoreboard testbench for dcache_direct
module tb_dcache_direct;

  localparam int SETS = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_re = 1'b0;
  logic        cpu_we = 1'b0;
  logic        cpu_byteop = 1'b0;
  logic [31:0] cpu_addr = '0;
  logic [31:0] cpu_wdata = '0;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        flush = 1'b0;
  logic        flush_busy;
  logic        mem_we;
  logic        mem_byteop;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  always #5 clk = ~clk;

  dcache_direct #(.SETS(SETS)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cpu_re     (cpu_re),
    .cpu_we     (cpu_we),
    .cpu_byteop (cpu_byteop),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_rdata  (cpu_rdata),
    .cpu_stall  (cpu_stall),
    .flush      (flush),
    .flush_busy (flush_busy),
    .mem_we     (mem_we),
    .mem_byteop (mem_byteop),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  // Memory seen by the DUT, and the bench's own reference copy.
  logic [31:0] mem     [1024];
  logic [31:0] ref_mem [1024];

  assign mem_rdata = mem[mem_addr[11:2]];

  always @(posedge clk) begin
    if (mem_we) begin
      if (mem_byteop)
        mem[mem_addr[11:2]][8*(3-int'(mem_addr[1:0])) +: 8] = mem_wdata[7:0];
      else
        mem[mem_addr[11:2]] = mem_wdata;
    end
  end

  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] a, input logic b);
    logic [31:0] w;
    int          off;
    w   = ref_mem[a[11:2]];
    off = int'(a[1:0]);
    if (!b) return w;
    return {24'b0, w[8*(3-off) +: 8]};
  endfunction

  // Called at posedge+1; leaves at posedge+1 with the request dropped.
  task automatic do_read(input string tag, input logic [31:0] a, input logic b, input int exp_stall);
    int n;
    exp_q.push_back(model_read(a, b));
    cpu_re = 1'b1; cpu_addr = a; cpu_byteop = b;
    n = 0;
    @(negedge clk);
    while (cpu_stall && n < 20) begin
      n++;
      @(negedge clk);
    end
    check({tag, "_stall"}, n, exp_stall);
    check({tag, "_data"}, cpu_rdata, exp_q.pop_front());
    @(posedge clk); #1;
    cpu_re = 1'b0;
  endtask

  task automatic do_write(input string tag, input logic [31:0] a, input logic b, input logic [31:0] d);
    int off;
    cpu_we = 1'b1; cpu_addr = a; cpu_byteop = b; cpu_wdata = d;
    @(negedge clk);
    check({tag, "_mem_we"}, mem_we, 1);
    check({tag, "_stall"}, cpu_stall, 0);
    check({tag, "_mem_addr"}, mem_addr, a);
    @(posedge clk); #1;
    cpu_we = 1'b0;
    off = int'(a[1:0]);
    if (b) ref_mem[a[11:2]][8*(3-off) +: 8] = d[7:0];
    else   ref_mem[a[11:2]] = d;
    check({tag, "_mem_word"}, mem[a[11:2]], ref_mem[a[11:2]]);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int busy, stall_low, we_seen, n;

    for (int i = 0; i < 1024; i++) begin
      mem[i]     = 32'h0;
      ref_mem[i] = 32'h0;
    end
    mem[0]     = 32'h1122_3344;   // byte address 0x10000
    ref_mem[0] = 32'h1122_3344;

    // Reset state
    @(negedge clk);
    check("rst_hit", hit_count, 0);
    check("rst_miss", miss_count, 0);
    check("rst_busy", flush_busy, 0);
    check("rst_stall", cpu_stall, 0);
    check("rst_mem_we", mem_we, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // 1: read miss then hit
    do_read("t1_miss", 32'h10000, 1'b0, 2);
    check("t1_miss_cnt", miss_count, 1);
    check("t1_hit_cnt", hit_count, 0);
    do_read("t1_hit", 32'h10000, 1'b0, 0);
    check("t1_hit_cnt2", hit_count, 1);

    // 2: byte reads, big-endian lanes
    for (int i = 0; i < 4; i++) begin
      do_read($sformatf("t2_b%0d", i), 32'h10000 + i, 1'b1, 0);
      check($sformatf("t2_hit_cnt%0d", i), hit_count, 2 + i);
    end

    // 3: byte write on a cached line
    do_write("t3_wr", 32'h10002, 1'b1, 32'h0000_00AB);
    do_read("t3_rd", 32'h10000, 1'b0, 0);
    check("t3_hit_cnt", hit_count, 6);

    // 4: write miss is not allocated
    do_write("t4_wr", 32'h10020, 1'b0, 32'hDEAD_BEEF);
    do_read("t4_old", 32'h10000, 1'b0, 0);
    do_read("t4_rd", 32'h10020, 1'b0, 2);
    check("t4_miss_cnt", miss_count, 2);
    check("t4_hit_cnt", hit_count, 7);

    // 5: conflict misses on the same index
    pulse_reset();
    check("t5_rst_miss", miss_count, 0);
    do_read("t5_a", 32'h10000, 1'b0, 2);
    do_read("t5_b", 32'h10000 + 4*SETS, 1'b0, 2);
    do_read("t5_a2", 32'h10000, 1'b0, 2);
    check("t5_miss_cnt", miss_count, 3);
    check("t5_hit_cnt", hit_count, 0);

    // 6: flush with a read pending
    exp_q.push_back(model_read(32'h10000, 1'b0));
    cpu_re = 1'b1; cpu_addr = 32'h10000; cpu_byteop = 1'b0; flush = 1'b1;
    @(negedge clk);
    check("t6_acc_stall", cpu_stall, 1);
    check("t6_acc_we", mem_we, 0);
    check("t6_acc_busy", flush_busy, 0);
    busy = 0; stall_low = 0; we_seen = 0; n = 0;
    @(negedge clk);
    while (flush_busy && n < 40) begin
      busy++;
      flush = 1'b0;
      if (!cpu_stall) stall_low++;
      if (mem_we) we_seen++;
      n++;
      @(negedge clk);
    end
    check("t6_busy_cycles", busy, SETS);
    check("t6_stall_low", stall_low, 0);
    check("t6_mem_we", we_seen, 0);
    n = 0;
    while (cpu_stall && n < 20) begin
      n++;
      @(negedge clk);
    end
    check("t6_refill_stall", n, 2);
    check("t6_data", cpu_rdata, exp_q.pop_front());
    @(posedge clk); #1;
    cpu_re = 1'b0;
    check("t6_miss_cnt", miss_count, 4);

    // 6b: reset mid-flush
    flush = 1'b1;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    flush = 1'b0;
    check("t6b_busy_before", flush_busy, 1);
    #1 rst_n = 1'b0;
    #1;
    check("t6b_busy", flush_busy, 0);
    check("t6b_stall", cpu_stall, 0);
    check("t6b_mem_we", mem_we, 0);
    check("t6b_hit", hit_count, 0);
    check("t6b_miss", miss_count, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    do_read("t6b_rd", 32'h10000, 1'b0, 2);
    check("t6b_miss_after", miss_count, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dcache_direct.md
Name: dcache_direct

Overview:
- Direct-mapped, write-through, no-write-allocate data cache between the CPU load/store path and the byte-addressed data memory.
- Holds one 32-bit word per set.
- Serves read hits with zero extra latency and refills read misses from memory.
- Passes every store straight through to memory, and supports a multi-cycle invalidate-all flush plus hit/miss statistics counters.

Parameters:
- ADDRESS_WIDTH, 32, byte address width.
- DATA_WIDTH, 32, word width. Fixed at 32.
- BYTE_WIDTH, 8, byte width.
- SETS, 8, number of cache lines. Power of two, at least 2.
- CNT_WIDTH, 32, width of the statistics counters.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- cpu_re  in  1  read request.
- cpu_we  in  1  write request. Wins over cpu_re when both are set.
- cpu_byteop  in  1  1 = byte access, 0 = word access.
- cpu_addr  in  ADDRESS_WIDTH  byte address.
- cpu_wdata  in  DATA_WIDTH  store data. Byte stores use bits [7:0].
- cpu_rdata  out  DATA_WIDTH  load data.
- cpu_stall  out  1  CPU must hold its request stable while this is high.
- flush  in  1  level request to invalidate all lines.
- flush_busy  out  1  high while flush is in progress.
- mem_we  out  1  memory write enable.
- mem_byteop  out  1  memory byte operation.
- mem_addr  out  ADDRESS_WIDTH  memory address.
- mem_wdata  out  DATA_WIDTH  memory write data.
- mem_rdata  in  DATA_WIDTH  memory read data. Combinational with respect to mem_addr; memory writes take effect on the clk edge.
- hit_count  out  CNT_WIDTH  read hit counter.
- miss_count  out  CNT_WIDTH  read miss counter.

Behaviour:
- Clock/reset (as decided): one clock, clk. rst_n is asynchronous, active-low.
- Reset clears:
  - all valid bits;
  - the FSM, to IDLE;
  - the flush index;
  - the just_filled flag;
  - hit_count and miss_count, to 0.
- Address split: IDX = log2(SETS); index = cpu_addr[IDX+1:2]; tag = cpu_addr[ADDRESS_WIDTH-1:IDX+2]; byte offset = cpu_addr[1:0].
- Word storage is big-endian, matching memory:
  - offset 0 → bits [31:24]; offset 3 → bits [7:0].
  - Word accesses ignore offset bits.
- hit = valid[index] && tag_array[index] == tag.
- cpu_rdata (combinational):
  - word access: the cached word;
  - byte access: {24'b0, selected byte}, zero-extended;
  - value is don't-care while cpu_stall = 1.
- FSM states: IDLE, FILL, FLUSH.
- IDLE, flush = 1:
  - Go to FLUSH.
  - cpu_stall = 1 and mem_we = 0, so any concurrent request is not performed this cycle.
- IDLE, cpu_we = 1:
  - mem_we = 1; mem_byteop/mem_addr/mem_wdata are the cpu_* values; cpu_stall = 0.
  - On a hit, update the cached copy at the same edge: full word, or only the addressed byte lane if cpu_byteop = 1.
  - On a miss, leave the cache unchanged (no allocate).
- IDLE, cpu_re = 1, hit:
  - cpu_stall = 0.
  - hit_count increments unless just_filled = 1.
  - Clear just_filled.
- IDLE, cpu_re = 1, miss:
  - cpu_stall = 1; go to FILL; miss_count increments.
- FILL:
  - cpu_stall = 1; mem_we = 0; mem_byteop = 0; mem_addr = {cpu_addr[31:2], 2'b00}.
  - At the edge, write mem_rdata into data[index], set tag[index] and valid[index], set just_filled, return to IDLE.
  - The next IDLE cycle hits: load miss penalty is exactly 2 cycles.
- FLUSH:
  - cpu_stall = 1; flush_busy = 1; mem_we = 0.
  - Clear valid[flush_idx] each cycle; flush_idx counts 0..SETS-1.
  - After clearing SETS-1, reset flush_idx to 0 and go to IDLE. A flush lasts exactly SETS cycles.
- flush is sampled only in IDLE. Requests arriving during FILL or FLUSH are ignored, so the requester holds flush high until flush_busy has been seen.
- The same flush that was held to the end is re-accepted if flush stays high on return to IDLE.
- Counters saturate at all-ones; they do not wrap.
- With no request active, mem_we = 0.
- Reset asserted mid-FILL or mid-FLUSH: immediate return to IDLE with all lines invalid; no memory write is issued.

Test Plan:
1. After reset, read word 0x10000 where memory holds 0x11223344 → cpu_stall high 2 cycles, cpu_rdata = 0x11223344; miss_count = 1, hit_count = 0. Repeat the read → no stall, hit_count = 1.
2. Byte reads 0x10000..0x10003 after the fill → 0x11, 0x22, 0x33, 0x44 zero-extended, no stalls, hit_count increments per read.
3. Byte write 0xAB to 0x10002 on a cached line → mem_we pulse, memory byte updated. Word read returns 0x1122AB44 with no stall.
4. Word write 0xDEADBEEF to an uncached address 0x10020, then read it → write passes through, cache unchanged. Read misses (2-cycle stall), then returns 0xDEADBEEF.
5. Conflict: read 0x10000 then 0x10000 + 4*SETS (same index) → both miss; re-reading 0x10000 misses again; miss_count = 3.
6. Flush with a read pending → flush_busy high exactly SETS cycles, cpu_stall high throughout, no mem_we. The next read of a previously cached address misses. rst_n pulsed mid-FLUSH → IDLE, counters 0.
